task_sequencer: RTL

//  Parametrised top-level scheduler for the render pipeline. It replaces the hard-wired

---
 rtl/task_sequencer_pkg.sv | 19 +
 rtl/task_sequencer_frame_limiter.sv | 32 +++
 rtl/task_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/task_sequencer_pkg.sv
// Shared definitions for the task sequencer: FSM state encodings and a width helper.
package task_sequencer_pkg;

  localparam logic [1:0] StBoot  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StSync  = 2'd3;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/task_sequencer_frame_limiter.sv
// Free-running frame limiter: down-counter producing a wrap tick and a VGA write window.
module task_sequencer_frame_limiter
  import task_sequencer_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = 1700000,
  parameter int unsigned WRITE_WINDOW = 1000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic frame_tick_o,
  output logic vga_write_en_o
);

  localparam int unsigned CntW = clog2(FRAME_CYCLES);
  localparam logic [CntW-1:0] Reload = CntW'(FRAME_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign frame_tick_o   = (cnt_q == '0);
  assign cnt_d          = frame_tick_o ? Reload : cnt_q - CntW'(1);
  // Window is the tail of the frame, so it closes on the tick cycle.
  assign vga_write_en_o = (32'(cnt_q) < WRITE_WINDOW);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= Reload;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/task_sequencer.sv
// Render-pipeline scheduler: run-once boot tasks, then a frame-synchronised task loop
// with per-task watchdog, pause, overrun statistics and a frame limiter.
module task_sequencer
  import task_sequencer_pkg::*;
#(
  parameter int unsigned NUM_TASKS    = 4,
  parameter int unsigned INIT_TASKS   = 1,
  parameter int unsigned FRAME_CYCLES = 1700000,
  parameter int unsigned WRITE_WINDOW = 1000,
  parameter int unsigned TIMEOUT      = 0,
  parameter int unsigned IDX_W        = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_TASKS-1:0] task_done_i,
  input  logic                 pause_i,
  output logic                 init_pulse_o,
  output logic [NUM_TASKS-1:0] task_start_o,
  output logic [IDX_W-1:0]     cur_task_o,
  output logic                 busy_o,
  output logic                 vga_write_en_o,
  output logic                 frame_tick_o,
  output logic [15:0]          frame_count_o,
  output logic [7:0]           overrun_cnt_o,
  output logic                 timeout_err_o,
  output logic [IDX_W-1:0]     err_task_o
);

  localparam int unsigned WdW = clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LastIdx     = IDX_W'(NUM_TASKS - 1);
  localparam logic [IDX_W-1:0] LastInitIdx = IDX_W'(INIT_TASKS - 1);
  // With no loop-only tasks the last init task is re-run every frame.
  localparam logic [IDX_W-1:0] LoopFirst   =
      (INIT_TASKS == NUM_TASKS) ? IDX_W'(INIT_TASKS - 1) : IDX_W'(INIT_TASKS);

  logic [1:0]           state_q, state_d;
  logic [IDX_W-1:0]     cur_q, cur_d;
  logic [WdW-1:0]       wd_q, wd_d;
  logic                 init_q, init_d;
  logic                 boot_q, boot_d;
  logic [15:0]          frame_q, frame_d;
  logic [7:0]           over_q, over_d;
  logic                 err_q, err_d;
  logic [IDX_W-1:0]     err_task_q, err_task_d;
  logic [NUM_TASKS-1:0] cur_onehot;
  logic                 frame_tick, done_now, expired;

  task_sequencer_frame_limiter #(
    .FRAME_CYCLES (FRAME_CYCLES),
    .WRITE_WINDOW (WRITE_WINDOW)
  ) u_limiter (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .frame_tick_o   (frame_tick),
    .vga_write_en_o (vga_write_en_o)
  );

  assign cur_onehot = NUM_TASKS'(1) << cur_q;
  assign done_now   = |(task_done_i & cur_onehot);
  assign expired    = (TIMEOUT != 0) && (wd_q == WdW'(1));

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    wd_d       = wd_q;
    init_d     = 1'b0;
    boot_d     = boot_q;
    frame_d    = frame_q;
    over_d     = over_q;
    err_d      = err_q;
    err_task_d = err_task_q;

    if (frame_tick && (state_q != StSync) && (over_q != 8'hff)) over_d = over_q + 8'd1;

    unique case (state_q)
      StBoot: begin
        init_d = ~init_q;
        if (init_q) begin
          state_d = StStart;
          cur_d   = '0;
        end
      end
      StStart: begin
        wd_d    = WdW'(TIMEOUT);
        state_d = StWait;
      end
      StWait: begin
        wd_d = wd_q - WdW'(1);
        if (done_now || expired) begin
          // Done has priority over a coincident expiry.
          if (!done_now) begin
            err_d      = 1'b1;
            err_task_d = cur_q;
          end
          if (cur_q == LastInitIdx) boot_d = 1'b0;
          if (cur_q != LastIdx) begin
            cur_d   = cur_q + IDX_W'(1);
            state_d = StStart;
          end else begin
            state_d = StSync;
            if (!boot_q) frame_d = frame_q + 16'd1;
          end
        end
      end
      StSync: begin
        if (frame_tick && !pause_i) begin
          cur_d   = LoopFirst;
          state_d = StStart;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StBoot;
      cur_q      <= '0;
      wd_q       <= '0;
      init_q     <= 1'b0;
      boot_q     <= 1'b1;
      frame_q    <= '0;
      over_q     <= '0;
      err_q      <= 1'b0;
      err_task_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      wd_q       <= wd_d;
      init_q     <= init_d;
      boot_q     <= boot_d;
      frame_q    <= frame_d;
      over_q     <= over_d;
      err_q      <= err_d;
      err_task_q <= err_task_d;
    end
  end

  assign init_pulse_o  = init_q;
  assign task_start_o  = (state_q == StStart) ? cur_onehot : '0;
  assign cur_task_o    = cur_q;
  assign busy_o        = (state_q == StStart) || (state_q == StWait);
  assign frame_tick_o  = frame_tick;
  assign frame_count_o = frame_q;
  assign overrun_cnt_o = over_q;
  assign timeout_err_o = err_q;
  assign err_task_o    = err_task_q;

endmodule
